// File: rtl/gate_sweep_ctrl.sv
// Sequencer that drives an AND-XOR gate through one or all sixteen input vectors,
// waits a settle time per vector, and checks each response against (a&b)^(c&d).
module gate_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 5
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [3:0]       vec_in_i,
    input  logic             gate_q_i,
    output logic             gate_a_o,
    output logic             gate_b_o,
    output logic             gate_c_o,
    output logic             gate_d_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [ERR_W-1:0] err_count_o,
    output logic [3:0]       first_fail_vec_o,
    output logic             first_fail_valid_o
);

    localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       vec_q, vec_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] settleCnt_q, settleCnt_d;
    logic [3:0]       drive_q, drive_d;
    logic [ERR_W-1:0] errCount_q, errCount_d;
    logic             pass_q, pass_d;
    logic [3:0]       failVec_q, failVec_d;
    logic             failValid_q, failValid_d;

    logic expected;
    logic mismatch;

    assign expected = (vec_q[3] & vec_q[2]) ^ (vec_q[1] & vec_q[0]);
    assign mismatch = (gate_q_i != expected);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            mode_q      <= 1'b0;
            settleCnt_q <= '0;
            drive_q     <= '0;
            errCount_q  <= '0;
            pass_q      <= 1'b0;
            failVec_q   <= '0;
            failValid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            mode_q      <= mode_d;
            settleCnt_q <= settleCnt_d;
            drive_q     <= drive_d;
            errCount_q  <= errCount_d;
            pass_q      <= pass_d;
            failVec_q   <= failVec_d;
            failValid_q <= failValid_d;
        end
    end

    // drive_d mirrors the vector that will be live next cycle, so the gate inputs
    // come straight from a flop and are zero outside SETTLE/SAMPLE.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        mode_d      = mode_q;
        settleCnt_d = settleCnt_q;
        drive_d     = drive_q;
        errCount_d  = errCount_q;
        pass_d      = pass_q;
        failVec_d   = failVec_q;
        failValid_d = failValid_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    vec_d       = mode_i ? vec_in_i : 4'h0;
                    mode_d      = mode_i;
                    errCount_d  = '0;
                    pass_d      = 1'b0;
                    failValid_d = 1'b0;
                    settleCnt_d = SETTLE_LOAD;
                    drive_d     = mode_i ? vec_in_i : 4'h0;
                    state_d     = SETTLE;
                end
            end
            SETTLE: begin
                if (settleCnt_q <= CNT_W'(1)) begin
                    state_d = SAMPLE;
                end else begin
                    settleCnt_d = settleCnt_q - CNT_W'(1);
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    if (errCount_q != {ERR_W{1'b1}}) begin
                        errCount_d = errCount_q + ERR_W'(1);
                    end
                    if (!failValid_q) begin
                        failVec_d   = vec_q;
                        failValid_d = 1'b1;
                    end
                end
                if (mode_q || (vec_q == 4'hF)) begin
                    drive_d = '0;
                    state_d = DONE;
                end else begin
                    vec_d       = vec_q + 4'd1;
                    drive_d     = vec_q + 4'd1;
                    settleCnt_d = SETTLE_LOAD;
                    state_d     = SETTLE;
                end
            end
            DONE: begin
                pass_d  = (errCount_q == '0);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gate_a_o           = drive_q[3];
    assign gate_b_o           = drive_q[2];
    assign gate_c_o           = drive_q[1];
    assign gate_d_o           = drive_q[0];
    assign busy_o             = (state_q != IDLE);
    assign done_o             = (state_q == DONE);
    assign pass_o             = pass_q;
    assign err_count_o        = errCount_q;
    assign first_fail_vec_o   = failVec_q;
    assign first_fail_valid_o = failValid_q;

endmodule

// File: doc/gate_sweep_ctrl.md
# gate_sweep_ctrl

Sequencer that drives the 4-input AND-XOR gate (q = (a & b) ^ (c & d)) through its test vectors and checks every response in hardware. On a start pulse it either sweeps all 16 input combinations or applies one caller-selected vector. For each vector it waits a programmable settle time, samples q and compares it with the expected value. It reports busy/done, a pass flag, a mismatch count and the first failing vector. It sits between a test or boot controller and the gate instance, replacing the hand-written stimulus sequence.

## Interface
- SETTLE_CYCLES, 2, cycles each vector is held before q is sampled; legal range is 1 or more.
- ERR_W, 5, width of the mismatch counter; legal range is 1 or more; the counter saturates at 2^ERR_W-1.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request pulse; accepted only in IDLE.
- mode  in  1  0 = full 16-vector sweep, 1 = single vector from vec_in; sampled at start.
- vec_in  in  4  single-mode vector {a,b,c,d}; sampled at start.
- gate_q  in  1  q output of the gate under control.
- gate_a, gate_b, gate_c, gate_d  out  1 each  registered drive to the gate inputs.
- busy  out  1  high from the cycle after start acceptance until DONE is left.
- done  out  1  one-cycle completion pulse.
- pass  out  1  1 if the last run had zero mismatches.
- err_count  out  ERR_W  mismatches counted in the last or current run.
- first_fail_vec  out  4  first mismatching vector in sweep order.
- first_fail_valid  out  1  first_fail_vec holds a captured value.

## Operation
- Vector encoding: vec[3]=a, vec[2]=b, vec[1]=c, vec[0]=d; gate_{a,b,c,d} = vec whenever busy, and 0 in IDLE/DONE.
- expected = (vec[3] & vec[2]) ^ (vec[1] & vec[0]).
- States:
  - IDLE: start=1 loads vec (0 if mode=0, else vec_in), latches mode, clears err_count/pass/first_fail_valid, loads settle counter and moves to SETTLE.
  - SETTLE: holds for SETTLE_CYCLES cycles, then moves to SAMPLE.
  - SAMPLE: one cycle. If gate_q != expected, err_count increments (saturating). On the first mismatch of the run, first_fail_vec <= vec and first_fail_valid <= 1. If this is the last vector (mode=1, or vec=4'hF in mode 0), go to DONE. Otherwise vec <= vec+1, reload the counter and go to SETTLE.
  - DONE: done=1 for one cycle, pass <= (err_count==0 after final sample), go to IDLE.
- Results (pass, err_count, first_fail_*) hold until the next accepted start.
- start in any state other than IDLE is ignored; it is neither queued nor does it restart the run.
- mode/vec_in changes after acceptance have no effect.
- vec does not wrap: a sweep ends at 4'hF.

## Timing
- Reset values: gate_* 0, busy 0, done 0, pass 0, err_count 0, first_fail_vec 0, first_fail_valid 0, state IDLE.
- rst_n low mid-run aborts immediately. No done pulse is produced and all outputs take their reset values.
- Start accepted at edge 0 → gate_* show the vector from cycle 1. q is sampled in cycle SETTLE_CYCLES+1.
- Per vector: SETTLE_CYCLES+1 cycles.
- done asserts in cycle N*(SETTLE_CYCLES+1)+1 after acceptance, where N=16 (sweep) or 1 (single). With defaults: 49 for a sweep, 4 for a single vector.
- busy is high in cycles 1..N*(SETTLE_CYCLES+1)+1 and falls together with done.
- A new start is accepted earliest on the cycle after done.
- gate_q is treated as synchronous to clk; no synchronizer is provided.

## Test plan
- Reset mid-sweep (rst_n low in vector 5) → next cycle busy=0, done=0, gate_*=0, err_count=0; no done pulse follows.
- Correct gate model, mode=0, defaults → single done pulse 49 cycles after start, pass=1, err_count=0, first_fail_valid=0.
- gate_q stuck at 0, mode=0 → err_count=6, first_fail_vec=4'b0011, first_fail_valid=1, pass=0. Same stimulus with ERR_W=2 → err_count saturates at 3.
- Gate model replaced by (a&b)|(c&d) → err_count=1, first_fail_vec=4'hF, pass=0.
- mode=1, vec_in=4'b1101, correct model → gate_a/b/c/d=1/1/0/1 in cycles 1-3, done in cycle 4, pass=1, err_count=0.
- start re-pulsed in cycles 10 and 49 of a sweep → both ignored, exactly one done at cycle 49, results unchanged; start at cycle 50 accepted normally.
